seq_multiplier: RTL
===================

# seq_multiplier

Parametrised sequential multiplier: a self-contained shift-add engine with its own bit counter, a run-time signed (radix-2 Booth) mode, an abort input and a registered 2·WIDTH-bit product. It sits beside the ALU in the multi-cycle datapath, is started by a one-cycle `St` request, and reports `Idle`/`Done` to the main control unit. It supersedes the fixed-width control-only multiplier, whose termination signal `K` came from outside.

## Interface
- `WIDTH`, default 8: operand width, ≥2; product is 2·WIDTH bits.
- `SIGNED_EN`, default 1: 1 = signed mode available; 0 = `Signed` ignored and forced to 0.

- `Clk`  in  1  single clock, all state on rising edge.
- `Rst_n`  in  1  reset, synchronous, active-low.
- `St`  in  1  start request, sampled only in IDLE.
- `Abort`  in  1  cancel the current operation.
- `Signed`  in  1  1 = two's-complement operands; latched at start.
- `A`  in  WIDTH  multiplicand, latched at start.
- `B`  in  WIDTH  multiplier, latched at start.
- `P`  out  2·WIDTH  product register.
- `Idle`  out  1  high in IDLE.
- `Done`  out  1  high for exactly one cycle when `P` is updated.

## Operation
- Registers: `Mcand` (WIDTH), `Acc` = {`Hi` (WIDTH+1), `Lo` (WIDTH)}, `Qm1` (Booth bit), `Cnt` (max(1,$clog2(WIDTH)) bits), `Mode`, `P`.
- States: IDLE, ADD, SHIFT, DONE. `Idle`/`Done` decode from the state register only (Moore).
- IDLE: if `St`: `Mcand`←`A`, `Hi`←0, `Lo`←`B`, `Qm1`←0, `Cnt`←0, `Mode`←`Signed & SIGNED_EN`; go to ADD. Otherwise stay.
- ADD, unsigned: if `Lo[0]`, `Hi`←`Hi`+zero-extended `Mcand`.
- ADD, signed: on {`Lo[0]`,`Qm1`} = 01, `Hi`←`Hi`+sign-extended `Mcand`; on 10, `Hi`←`Hi`−sign-extended `Mcand`; otherwise no change.
- ADD always goes to SHIFT.
- SHIFT: {`Hi`,`Lo`,`Qm1`} shifts right by 1. The fill bit is 0 in unsigned mode and `Hi[WIDTH]` (arithmetic) in signed mode. `Cnt`←`Cnt`+1.
- SHIFT exit: if `Cnt`==WIDTH−1 before the increment, `P`←{`Hi[WIDTH-1:0]`,`Lo`} after the shift and go to DONE. Otherwise go to ADD.
- DONE: always goes to IDLE.
- `Hi` is WIDTH+1 bits so that the unsigned carry and the signed case −2^(W−1)·−2^(W−1) are exact. All arithmetic is modulo 2^(WIDTH+1) on `Hi`.
- `P` changes only on DONE entry or reset. It holds its value across IDLE, aborts and new operations until overwritten.

## Timing
- Reset (`Rst_n`=0 at an edge): state=IDLE, `P`=0, `Acc`=0, `Cnt`=0, `Mode`=0. Outputs `Idle`=1, `Done`=0, `P`=0. Applies from any state, mid-operation included.
- Priority at each edge: reset > `Abort` > `St`.
- `Abort`=1 in ADD/SHIFT/DONE: next state IDLE, `P` unchanged, no `Done` pulse. In IDLE, `Abort` blocks `St`.
- Latency, with `St` sampled at edge 0:
  - ADD/SHIFT alternate over edges 1..2·WIDTH.
  - `P` is written at edge 2·WIDTH.
  - `Done`=1 between edges 2·WIDTH and 2·WIDTH+1.
  - `Idle`=1 again after edge 2·WIDTH+1.
- `St` outside IDLE is ignored and is not queued. `St` held high restarts at edge 2·WIDTH+2, giving a period of 2·WIDTH+2 cycles.
- `A`, `B` and `Signed` are don't-care except at the start edge.

## Structure
- Package `mult_pkg`:
  - state typedef: IDLE=2'd0, ADD=2'd1, SHIFT=2'd2, DONE=2'd3.
  - Booth-op encoding: NOP, ADD, SUB.
  - function for counter width.
- Sub-module `seq_mult_ctrl`: the FSM plus `Cnt`. It issues `Load`, `Ad`, `Sub`, `Sh` and `Wr` to the datapath and generates `Idle`/`Done`.
- Top `seq_multiplier` holds the datapath registers and the adder/subtractor.

## Test plan
- WIDTH=8, unsigned, A=13, B=11, `St` 1 cycle → `P`=143 (0x008F). `Done` is high one cycle, 16 edges after the start edge; `Idle` is low for 17 cycles.
- Unsigned 0xFF·0xFF → `P`=0xFE01. Signed 0x80·0x80 → 0x4000. Signed 0xFD·0x05 → 0xFFF1. Signed 0x7F·0x80 → 0xC080.
- SIGNED_EN=0, `Signed`=1, 0xFF·0x02 → `P`=0x01FE (unsigned result).
- After the 143 result, start 5·5 and assert `Abort` in the 4th ADD → `Idle`=1 next cycle, no `Done`, `P` stays 0x008F.
- `St` pulsed during SHIFT → ignored. `St` held high with 3·4 → `Done` pulses 18 cycles apart, `P`=12 each time.
- `Rst_n`=0 at edge 5 of an operation → next cycle `Idle`=1, `Done`=0, `P`=0. A new 2·3 then gives `P`=6 with nominal latency.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the sequential shift-add multiplier.
//   state_e    - controller state encoding
//   booth_op_e - operation applied to Hi during an ADD step
//   cnt_width  - bit counter width, max(1, clog2(width))
//   booth_op   - selects the ADD-step operation from mode and the low bits
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  function automatic int cnt_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

  // Unsigned mode adds on a set multiplier bit; signed mode uses radix-2
  // Booth recoding of the {Lo[0], Qm1} pair.
  function automatic booth_op_e booth_op(input logic mode, input logic lo0,
                                         input logic qm1);
    if (!mode) begin
      return lo0 ? OP_ADD : OP_NOP;
    end
    case ({lo0, qm1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequencing FSM and bit counter for seq_multiplier.
// Ports:
//   Clk, Rst_n      clock, synchronous active-low reset
//   St, Abort       start request, cancel
//   op              ADD-step operation selected by the datapath bits
//   Load            load operands and clear accumulator
//   Ad, Sub         add / subtract the multiplicand into Hi
//   Sh              shift {Hi, Lo, Qm1} right by one
//   Wr              write the product register
//   Idle, Done      status, decoded from the state register only
//
// state | meaning
// IDLE  | waiting for St; Abort blocks a start
// ADD   | conditional add/subtract of the multiplicand into Hi
// SHIFT | shift accumulator, count bits; last bit writes P
// DONE  | one-cycle completion indication, returns to IDLE
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      Clk,
  input  logic      Rst_n,
  input  logic      St,
  input  logic      Abort,
  input  booth_op_e op,
  output logic      Load,
  output logic      Ad,
  output logic      Sub,
  output logic      Sh,
  output logic      Wr,
  output logic      Idle,
  output logic      Done
);

  localparam int CW = cnt_width(WIDTH);

  state_e          state;
  state_e          state_nxt;
  logic [CW-1:0]   cnt;
  logic            last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (Load) begin
        cnt <= '0;
      end else if (Sh) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Every datapath command is suppressed while Abort is high, so an abort
  // never disturbs P and never produces a Done pulse.
  always_comb begin
    state_nxt = state;
    Load      = 1'b0;
    Ad        = 1'b0;
    Sub       = 1'b0;
    Sh        = 1'b0;
    Wr        = 1'b0;
    case (state)
      IDLE: begin
        if (!Abort && St) begin
          Load      = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (Abort) begin
          state_nxt = IDLE;
        end else begin
          Ad        = (op == OP_ADD);
          Sub       = (op == OP_SUB);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (Abort) begin
          state_nxt = IDLE;
        end else begin
          Sh = 1'b1;
          if (last_bit) begin
            Wr        = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = ADD;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign Idle = (state == IDLE);
  assign Done = (state == DONE);

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier with optional radix-2 Booth
// signed mode, abort, and a registered 2*WIDTH-bit product.
// Ports:
//   Clk     clock, all state on the rising edge
//   Rst_n   synchronous active-low reset
//   St      start request, sampled only while idle
//   Abort   cancel the current operation (wins over St)
//   Signed  two's-complement operands, latched at start
//   A, B    multiplicand / multiplier, latched at start
//   P       product register, updated only on completion or reset
//   Idle    high while waiting for a start
//   Done    one-cycle pulse in the cycle after P is written
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               St,
  input  logic               Abort,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               Idle,
  output logic               Done
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic             qm1;
  logic             mode;

  logic             load;
  logic             ad;
  logic             sub;
  logic             sh;
  logic             wr;
  booth_op_e        op;
  logic [WIDTH:0]   mcand_ext;
  logic             fill;

  assign op        = booth_op(mode, lo[0], qm1);
  assign mcand_ext = mode ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
  assign fill      = mode ? hi[WIDTH] : 1'b0;

  seq_mult_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .St    (St),
    .Abort (Abort),
    .op    (op),
    .Load  (load),
    .Ad    (ad),
    .Sub   (sub),
    .Sh    (sh),
    .Wr    (wr),
    .Idle  (Idle),
    .Done  (Done)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      qm1   <= 1'b0;
      mode  <= 1'b0;
      P     <= '0;
    end else begin
      if (load) begin
        mcand <= A;
        hi    <= '0;
        lo    <= B;
        qm1   <= 1'b0;
        mode  <= (SIGNED_EN != 0) ? Signed : 1'b0;
      end else if (ad) begin
        hi <= hi + mcand_ext;
      end else if (sub) begin
        hi <= hi - mcand_ext;
      end else if (sh) begin
        {hi, lo, qm1} <= {fill, hi, lo};
      end
      // Post-shift {Hi[W-1:0], Lo} equals pre-shift {Hi, Lo[W-1:1]}.
      if (wr) begin
        P <= {hi, lo[WIDTH-1:1]};
      end
    end
  end

endmodule
